// File: rtl/control_fsm.sv
// Sequencer for a 16-register datapath with an add/sub ALU.
// Decodes MV, MVI, ADD and SUB into per-step bus and load controls.
module control_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] instr,
  output logic [4:0]  mux_sel,
  output logic [15:0] reg_load,
  output logic        a_load,
  output logic        g_load,
  output logic        alu_sub,
  output logic        busy,
  output logic        done,
  output logic        illegal
);

  typedef enum logic [1:0] {
    IDLE,
    T1,
    T2,
    T3
  } state_e;

  typedef struct packed {
    logic [4:0]  mux_sel;
    logic [15:0] reg_load;
    logic        a_load;
    logic        g_load;
    logic        alu_sub;
    logic        busy;
    logic        done;
    logic        illegal;
  } ctl_t;

  localparam logic [4:0] SEL_G   = 5'd17;
  localparam logic [4:0] SEL_DIN = 5'd18;

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  ctl_t        ctl_q, ctl_d;

  // Controls for a step are a pure function of (state, IR); they are
  // computed from the next-state values so the outputs can be registered.
  function automatic ctl_t decode(
    input state_e      st,
    input logic [15:0] ir
  );
    ctl_t        c;
    logic [3:0]  op;
    logic [4:0]  rx1;
    logic [4:0]  ry1;
    logic [15:0] rx_oh;
    c     = '0;
    op    = ir[15:12];
    rx1   = {1'b0, ir[11:8]} + 5'd1;
    ry1   = {1'b0, ir[7:4]} + 5'd1;
    rx_oh = 16'd1 << ir[11:8];
    c.busy = (st != IDLE);
    unique case (st)
      IDLE: c = '0;
      T1: begin
        case (op)
          4'h0: begin
            c.mux_sel  = ry1;
            c.reg_load = rx_oh;
            c.done     = 1'b1;
          end
          4'h1: begin
            c.mux_sel  = SEL_DIN;
            c.reg_load = rx_oh;
            c.done     = 1'b1;
          end
          4'h2, 4'h3: begin
            c.mux_sel = rx1;
            c.a_load  = 1'b1;
          end
          default: begin
            c.done    = 1'b1;
            c.illegal = 1'b1;
          end
        endcase
      end
      T2: begin
        c.mux_sel = ry1;
        c.g_load  = 1'b1;
        c.alu_sub = op[0];
      end
      T3: begin
        c.mux_sel  = SEL_G;
        c.reg_load = rx_oh;
        c.done     = 1'b1;
      end
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    unique case (state_q)
      IDLE: begin
        if (run) begin
          state_d = T1;
          ir_d    = instr;
        end
      end
      T1: state_d = (ir_q[15:13] == 3'b001) ? T2 : IDLE;
      T2: state_d = T3;
      T3: state_d = IDLE;
    endcase
    ctl_d = decode(state_d, ir_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ir_q    <= '0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      ctl_q   <= ctl_d;
    end
  end

  assign mux_sel  = ctl_q.mux_sel;
  assign reg_load = ctl_q.reg_load;
  assign a_load   = ctl_q.a_load;
  assign g_load   = ctl_q.g_load;
  assign alu_sub  = ctl_q.alu_sub;
  assign busy     = ctl_q.busy;
  assign done     = ctl_q.done;
  assign illegal  = ctl_q.illegal;

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: expected step vectors are queued
// as instructions are issued and popped one per clock.
module tb_control_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [15:0] instr;
  logic [4:0]  mux_sel;
  logic [15:0] reg_load;
  logic        a_load;
  logic        g_load;
  logic        alu_sub;
  logic        busy;
  logic        done;
  logic        illegal;

  logic [26:0] exp_q[$];
  int          n_run  = 0;
  int          n_fail = 0;

  localparam logic [26:0] IDLE_V = 27'd0;

  control_fsm dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .instr    (instr),
    .mux_sel  (mux_sel),
    .reg_load (reg_load),
    .a_load   (a_load),
    .g_load   (g_load),
    .alu_sub  (alu_sub),
    .busy     (busy),
    .done     (done),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [26:0] pk(
    input logic [4:0]  m,
    input logic [15:0] r,
    input logic a, input logic g, input logic s,
    input logic b, input logic d, input logic i
  );
    return {m, r, a, g, s, b, d, i};
  endfunction

  function automatic logic [26:0] obs();
    return {mux_sel, reg_load, a_load, g_load,
            alu_sub, busy, done, illegal};
  endfunction

  task automatic check_eq(
    input string       tag,
    input logic [26:0] got,
    input logic [26:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (mux,rl,a,g,s,b,d,i)",
               tag, got, exp);
    end
  endtask

  // Expected output of each step, straight from the instruction table.
  task automatic push_seq(input logic [15:0] ins);
    logic [3:0]  op;
    logic [4:0]  rx1;
    logic [4:0]  ry1;
    logic [15:0] oh;
    op  = ins[15:12];
    rx1 = {1'b0, ins[11:8]} + 5'd1;
    ry1 = {1'b0, ins[7:4]} + 5'd1;
    oh  = 16'h0001 << ins[11:8];
    case (op)
      4'h0: exp_q.push_back(pk(ry1, oh, 0, 0, 0, 1, 1, 0));
      4'h1: exp_q.push_back(pk(5'd18, oh, 0, 0, 0, 1, 1, 0));
      4'h2, 4'h3: begin
        exp_q.push_back(pk(rx1, 16'h0, 1, 0, 0, 1, 0, 0));
        exp_q.push_back(pk(ry1, 16'h0, 0, 1, op[0], 1, 0, 0));
        exp_q.push_back(pk(5'd17, oh, 0, 0, 0, 1, 1, 0));
      end
      default: exp_q.push_back(pk(5'd0, 16'h0, 0, 0, 0, 1, 1, 1));
    endcase
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_run++;
      n_fail++;
      $display("FAIL %s scoreboard empty got=%h", tag, obs());
    end else begin
      check_eq(tag, obs(), exp_q.pop_front());
    end
  endtask

  // Issue one instruction with a single-cycle run pulse, scrambling
  // instr while busy, then confirm the return to idle.
  task automatic exec(input string tag, input logic [15:0] ins);
    int n;
    push_seq(ins);
    exp_q.push_back(IDLE_V);
    n = exp_q.size();
    run   = 1'b1;
    instr = ins;
    tick(tag);
    run = 1'b0;
    for (int k = 1; k < n; k++) begin
      instr = 16'($urandom);
      tick(tag);
    end
  endtask

  initial begin
    logic [15:0] r;
    reset = 1'b1;
    run   = 1'b0;
    instr = 16'h0;
    #12;
    check_eq("reset", obs(), IDLE_V);
    #5 reset = 1'b0;
    exp_q.push_back(IDLE_V);
    tick("idle_no_run");

    exec("mv_0350", 16'h0350);
    exec("add_2F20", 16'h2F20);
    exec("sub_3120", 16'h3120);
    exec("mvi_1700", 16'h1700);
    exec("ill_A000", 16'hA000);
    exec("add_r3r3", 16'h2330);
    exec("mv_r15", 16'h0FF0);

    // literal spot checks for the documented MV case
    run = 1'b1; instr = 16'h0350;
    @(posedge clk); #1;
    run = 1'b0;
    check_eq("mv_lit_t1", obs(),
             pk(5'd6, 16'h0008, 0, 0, 0, 1, 1, 0));
    @(posedge clk); #1;
    check_eq("mv_lit_idle", obs(), IDLE_V);

    // async reset in T2 of ADD; T3 must never appear
    push_seq(16'h2F20);
    run = 1'b1; instr = 16'h2F20;
    tick("rst_t1");
    run = 1'b0;
    tick("rst_t2");
    #2 reset = 1'b1;
    #1 check_eq("rst_async", obs(), IDLE_V);
    exp_q.delete();
    @(posedge clk);
    #2 reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(IDLE_V);
      tick("post_rst");
    end

    // run held high: back-to-back MV every 2 cycles
    push_seq(16'h0120);
    exp_q.push_back(IDLE_V);
    push_seq(16'h0540);
    exp_q.push_back(IDLE_V);
    run = 1'b1; instr = 16'h0120;
    tick("b2b_a");
    instr = 16'h0540;
    tick("b2b_gap");
    tick("b2b_b");
    run = 1'b0;
    tick("b2b_end");

    // instr changed while busy is ignored; IDLE-edge value wins
    push_seq(16'h2120);
    exp_q.push_back(IDLE_V);
    push_seq(16'h0450);
    exp_q.push_back(IDLE_V);
    run = 1'b1; instr = 16'h2120;
    tick("hold_t1");
    instr = 16'h3ABC;
    tick("hold_t2");
    instr = 16'h1F00;
    tick("hold_t3");
    instr = 16'h0450;
    tick("hold_idle");
    tick("hold_mv");
    run = 1'b0;
    tick("hold_end");

    for (int k = 0; k < 24; k++) begin
      r = 16'($urandom);
      if (k % 3 != 0) r[15:12] = 4'($urandom_range(0, 3));
      exec("rand", r);
    end

    if (exp_q.size() != 0) begin
      n_run++;
      n_fail++;
      $display("FAIL leftover %0d entries", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
